// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional build macro: FETCH_PERF_EN (adds fetch/stall performance counters).
package fetch_pkg;

    localparam int          DATA_WIDTH_DEF = 32;
    localparam int          ADDR_WIDTH_DEF = 32;

    // addi x0, x0, 0 -- the canonical RISC-V no-op used for pipeline bubbles
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // IDLE: ready to issue; WAIT: request outstanding; HOLD: response parked
    // in the skid buffer behind a decode stall; DROP: request outstanding but
    // its response must be thrown away because a redirect overtook it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding register. Parks an instruction that returned
// from memory while decode was stalled, until decode can accept it.
// Clear has priority over load.
module fetch_skid_buffer
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] instr_in,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  valid
);

    logic [DATA_WIDTH-1:0] instr_r;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic                  valid_r;

    // Capture or release the parked instruction; data is kept on clear, only valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r <= DATA_WIDTH'(NOP_INSTR);
            pc_r    <= {ADDR_WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else if (clear) begin
            instr_r <= instr_r;
            pc_r    <= pc_r;
            valid_r <= 1'b0;
        end else if (load) begin
            instr_r <= instr_in;
            pc_r    <= pc_in;
            valid_r <= 1'b1;
        end else begin
            instr_r <= instr_r;
            pc_r    <= pc_r;
            valid_r <= valid_r;
        end
    end

    assign instr = instr_r;
    assign pc    = pc_r;
    assign valid = valid_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. Keeps a single
// request outstanding to instruction memory, parks responses that arrive
// during a decode stall, and flushes on branch/jump redirects.
// Optional build macro: FETCH_PERF_EN adds FetchCount / StallCount outputs.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Stall,
    input  logic                  Redirect,
    input  logic [ADDR_WIDTH-1:0] PCTarget,
    output logic                  ImemReq,
    output logic [ADDR_WIDTH-1:0] ImemAddr,
    input  logic                  ImemValid,
    input  logic [DATA_WIDTH-1:0] ImemRdata,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [ADDR_WIDTH-1:0] PCD,
    output logic [ADDR_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           FetchCount,
    output logic [31:0]           StallCount
`endif
);

    fetch_state_t          state_r;
    logic [ADDR_WIDTH-1:0] pcf_r;
    logic [ADDR_WIDTH-1:0] pcf_plus4_s;
    logic [ADDR_WIDTH-1:0] target_s;

    logic [DATA_WIDTH-1:0] instr_d_r;
    logic [ADDR_WIDTH-1:0] pc_d_r;
    logic [ADDR_WIDTH-1:0] pc_plus4_d_r;
    logic                  valid_d_r;

    logic                  imem_req_s;
    logic                  deliver_mem_s;
    logic                  deliver_skid_s;
    logic                  skid_load_s;
    logic                  skid_clear_s;

    logic [DATA_WIDTH-1:0] skid_instr_s;
    logic [ADDR_WIDTH-1:0] skid_pc_s;
    logic                  skid_valid_s;
    logic [ADDR_WIDTH-1:0] skid_pc_plus4_s;

    // Word-align the redirect target; PC arithmetic wraps naturally at 2^ADDR_WIDTH.
    assign target_s        = PCTarget & ~(ADDR_WIDTH'(3));
    assign pcf_plus4_s     = pcf_r + ADDR_WIDTH'(4);
    assign skid_pc_plus4_s = skid_pc_s + ADDR_WIDTH'(4);

    // Request strobe straight from the state; suppressed while a redirect is being taken and during reset.
    always_comb begin
        imem_req_s = 1'b0;
        if (rst_n && (state_r == IDLE) && !Redirect) begin
            imem_req_s = 1'b1;
        end else begin
            imem_req_s = 1'b0;
        end
    end

    // Decode which datapath event happens this cycle; Redirect overrides everything.
    always_comb begin
        deliver_mem_s  = 1'b0;
        deliver_skid_s = 1'b0;
        skid_load_s    = 1'b0;
        skid_clear_s   = 1'b0;
        if (Redirect) begin
            skid_clear_s = (state_r == HOLD);
        end else begin
            case (state_r)
                WAIT: begin
                    deliver_mem_s = ImemValid && !Stall;
                    skid_load_s   = ImemValid && Stall;
                end
                HOLD: begin
                    deliver_skid_s = !Stall && skid_valid_s;
                    skid_clear_s   = !Stall;
                end
                default: begin
                    deliver_mem_s  = 1'b0;
                    deliver_skid_s = 1'b0;
                end
            endcase
        end
    end

    // Fetch FSM and PC register; priority Redirect > ImemValid > Stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            pcf_r   <= RESET_PC;
        end else begin
            case (state_r)
                IDLE: begin
                    if (Redirect) begin
                        pcf_r   <= target_s;
                        state_r <= IDLE;
                    end else begin
                        pcf_r   <= pcf_r;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (Redirect) begin
                        // A response in the same cycle is consumed and dropped;
                        // otherwise its later arrival must be swallowed in DROP.
                        pcf_r   <= target_s;
                        state_r <= ImemValid ? IDLE : DROP;
                    end else if (ImemValid) begin
                        pcf_r   <= pcf_plus4_s;
                        state_r <= Stall ? HOLD : IDLE;
                    end else begin
                        pcf_r   <= pcf_r;
                        state_r <= WAIT;
                    end
                end
                HOLD: begin
                    if (Redirect) begin
                        pcf_r   <= target_s;
                        state_r <= IDLE;
                    end else if (!Stall) begin
                        pcf_r   <= pcf_r;
                        state_r <= IDLE;
                    end else begin
                        pcf_r   <= pcf_r;
                        state_r <= HOLD;
                    end
                end
                DROP: begin
                    if (Redirect) begin
                        // If the stale response lands now, it is the one we
                        // were waiting to discard, so we are free to issue.
                        pcf_r   <= target_s;
                        state_r <= ImemValid ? IDLE : DROP;
                    end else if (ImemValid) begin
                        pcf_r   <= pcf_r;
                        state_r <= IDLE;
                    end else begin
                        pcf_r   <= pcf_r;
                        state_r <= DROP;
                    end
                end
                default: begin
                    pcf_r   <= pcf_r;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // IF/ID register: flush on redirect, load on delivery, hold on stall, else insert a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_d_r    <= DATA_WIDTH'(NOP_INSTR);
            pc_d_r       <= {ADDR_WIDTH{1'b0}};
            pc_plus4_d_r <= {ADDR_WIDTH{1'b0}};
            valid_d_r    <= 1'b0;
        end else if (Redirect) begin
            instr_d_r    <= DATA_WIDTH'(NOP_INSTR);
            pc_d_r       <= pc_d_r;
            pc_plus4_d_r <= pc_plus4_d_r;
            valid_d_r    <= 1'b0;
        end else if (deliver_mem_s) begin
            instr_d_r    <= ImemRdata;
            pc_d_r       <= pcf_r;
            pc_plus4_d_r <= pcf_plus4_s;
            valid_d_r    <= 1'b1;
        end else if (deliver_skid_s) begin
            instr_d_r    <= skid_instr_s;
            pc_d_r       <= skid_pc_s;
            pc_plus4_d_r <= skid_pc_plus4_s;
            valid_d_r    <= 1'b1;
        end else if (Stall) begin
            instr_d_r    <= instr_d_r;
            pc_d_r       <= pc_d_r;
            pc_plus4_d_r <= pc_plus4_d_r;
            valid_d_r    <= valid_d_r;
        end else begin
            instr_d_r    <= DATA_WIDTH'(NOP_INSTR);
            pc_d_r       <= pc_d_r;
            pc_plus4_d_r <= pc_plus4_d_r;
            valid_d_r    <= 1'b0;
        end
    end

    fetch_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load_s),
        .clear    (skid_clear_s),
        .instr_in (ImemRdata),
        .pc_in    (pcf_r),
        .instr    (skid_instr_s),
        .pc       (skid_pc_s),
        .valid    (skid_valid_s)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_r;
    logic [31:0] stall_count_r;

    // Count instructions handed to decode and cycles spent parked behind a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_r <= 32'd0;
            stall_count_r <= 32'd0;
        end else begin
            if (deliver_mem_s || deliver_skid_s) begin
                fetch_count_r <= fetch_count_r + 32'd1;
            end else begin
                fetch_count_r <= fetch_count_r;
            end
            if (state_r == HOLD) begin
                stall_count_r <= stall_count_r + 32'd1;
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign FetchCount = fetch_count_r;
    assign StallCount = stall_count_r;
`endif

    assign ImemReq  = imem_req_s;
    assign ImemAddr = pcf_r;
    assign InstrD   = instr_d_r;
    assign PCD      = pc_d_r;
    assign PCPlus4D = pc_plus4_d_r;
    assign ValidD   = valid_d_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small memory responder with programmable
// latency answers every ImemReq; checks are taken on the falling clock edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Stall;
    logic        Redirect;
    logic [31:0] PCTarget;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemValid = 1'b0;
    logic [31:0] ImemRdata = 32'd0;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_EN
    logic [31:0] FetchCount;
    logic [31:0] StallCount;
`endif

    int          tests = 0;
    int          fails = 0;
    int          mem_lat = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'd0;
    logic        req_smp;
    logic [31:0] addr_smp;

    fetch_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Stall     (Stall),
        .Redirect  (Redirect),
        .PCTarget  (PCTarget),
        .ImemReq   (ImemReq),
        .ImemAddr  (ImemAddr),
        .ImemValid (ImemValid),
        .ImemRdata (ImemRdata),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount(FetchCount),
        .StallCount(StallCount)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // Memory model: a request seen at a rising edge is answered mem_lat cycles later.
    always @(posedge clk) begin
        req_smp  = ImemReq;
        addr_smp = ImemAddr;
        #1;
        ImemValid = 1'b0;
        if (req_smp) begin
            pend_addr = addr_smp;
            pend_cnt  = mem_lat;
        end
        if (pend_cnt > 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                ImemValid = 1'b1;
                ImemRdata = mem_word(pend_addr);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; Stall = 1'b0; Redirect = 1'b0; PCTarget = 32'd0;

        // Reset state
        tick();
        check("rst_req",   {31'd0, ImemReq}, 32'd0);
        check("rst_addr",  ImemAddr, 32'd0);
        check("rst_instr", InstrD, NOP);
        check("rst_pcd",   PCD, 32'd0);
        check("rst_pc4",   PCPlus4D, 32'd0);
        check("rst_valid", {31'd0, ValidD}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Test 1: 1-cycle memory, sequential fetch on alternate cycles
        tick();
        check("t1_wait_req", {31'd0, ImemReq}, 32'd0);
        tick();
        check("t1_instr0", InstrD, mem_word(32'h0));
        check("t1_pcd0",   PCD, 32'h0);
        check("t1_pc4_0",  PCPlus4D, 32'h4);
        check("t1_valid0", {31'd0, ValidD}, 32'd1);
        check("t1_req4",   {31'd0, ImemReq}, 32'd1);
        check("t1_addr4",  ImemAddr, 32'h4);
        tick();
        check("t1_bubble", {31'd0, ValidD}, 32'd0);
        check("t1_noreq",  {31'd0, ImemReq}, 32'd0);
        tick();
        check("t1_instr4", InstrD, mem_word(32'h4));
        check("t1_pcd4",   PCD, 32'h4);
        check("t1_pc4_4",  PCPlus4D, 32'h8);
        check("t1_addr8",  ImemAddr, 32'h8);

        // Test 2: stall across the response for PC 8
        Stall = 1'b1;
        tick();
        check("t2_hold_instr", InstrD, mem_word(32'h4));
        check("t2_hold_valid", {31'd0, ValidD}, 32'd1);
        tick();
        check("t2_hold_req",   {31'd0, ImemReq}, 32'd0);
        check("t2_hold_addr",  ImemAddr, 32'hC);
        check("t2_hold_instr2", InstrD, mem_word(32'h4));
        tick();
        check("t2_hold_req2",  {31'd0, ImemReq}, 32'd0);
        check("t2_hold_pcd",   PCD, 32'h4);
        tick();
        Stall = 1'b0;
        tick();
        check("t2_instr8", InstrD, mem_word(32'h8));
        check("t2_pcd8",   PCD, 32'h8);
        check("t2_pc4_8",  PCPlus4D, 32'hC);
        check("t2_valid8", {31'd0, ValidD}, 32'd1);
        check("t2_req12",  {31'd0, ImemReq}, 32'd1);
        check("t2_addr12", ImemAddr, 32'hC);
`ifdef FETCH_PERF_EN
        check("t2_fetchcnt", FetchCount, 32'd3);
        check("t2_stallcnt", StallCount, 32'd3);
`endif

        // Test 3: redirect while waiting on a 3-cycle memory
        mem_lat = 3;
        tick();
        check("t3_wait_req", {31'd0, ImemReq}, 32'd0);
        Redirect = 1'b1; PCTarget = 32'h100;
        tick();
        Redirect = 1'b0;
        check("t3_flush_valid", {31'd0, ValidD}, 32'd0);
        check("t3_flush_instr", InstrD, NOP);
        check("t3_drop_req",    {31'd0, ImemReq}, 32'd0);
        check("t3_drop_addr",   ImemAddr, 32'h100);
        tick();
        check("t3_drop_req2",   {31'd0, ImemReq}, 32'd0);
        tick();
        check("t3_req100",   {31'd0, ImemReq}, 32'd1);
        check("t3_addr100",  ImemAddr, 32'h100);
        check("t3_stale_v",  {31'd0, ValidD}, 32'd0);
        tick(); tick(); tick();
        check("t3_wait_v",   {31'd0, ValidD}, 32'd0);
        tick();
        check("t3_instr100", InstrD, mem_word(32'h100));
        check("t3_pcd100",   PCD, 32'h100);
        check("t3_pc4_100",  PCPlus4D, 32'h104);
        check("t3_valid100", {31'd0, ValidD}, 32'd1);

        // Test 4: Redirect and Stall together with the response
        mem_lat = 1;
        tick();
        Redirect = 1'b1; Stall = 1'b1; PCTarget = 32'h200;
        tick();
        check("t4_instr_nop", InstrD, NOP);
        check("t4_valid",     {31'd0, ValidD}, 32'd0);
        check("t4_addr",      ImemAddr, 32'h200);
        Redirect = 1'b0; Stall = 1'b0;
        tick();
        check("t4_wait_req",  {31'd0, ImemReq}, 32'd0);
        tick();
        check("t4_instr200",  InstrD, mem_word(32'h200));
        check("t4_pcd200",    PCD, 32'h200);

        // Test 5: PC wrap and target alignment
        Redirect = 1'b1; PCTarget = 32'hFFFF_FFFC;
        tick();
        Redirect = 1'b0;
        check("t5_addr_top",  ImemAddr, 32'hFFFF_FFFC);
        check("t5_flush_v",   {31'd0, ValidD}, 32'd0);
        tick();
        tick();
        check("t5_instr_top", InstrD, mem_word(32'hFFFF_FFFC));
        check("t5_pcd_top",   PCD, 32'hFFFF_FFFC);
        check("t5_pc4_wrap",  PCPlus4D, 32'h0);
        check("t5_addr_wrap", ImemAddr, 32'h0);
        Redirect = 1'b1; PCTarget = 32'h103;
        tick();
        Redirect = 1'b0;
        check("t5_addr_align", ImemAddr, 32'h100);
`ifdef FETCH_PERF_EN
        check("t5_fetchcnt", FetchCount, 32'd6);
`endif

        // Test 6: reset in the middle of an outstanding request
        mem_lat = 2;
        tick();
        check("t6_wait_req", {31'd0, ImemReq}, 32'd0);
        rst_n = 1'b0;
        tick();
        check("t6_rst_req",   {31'd0, ImemReq}, 32'd0);
        check("t6_rst_addr",  ImemAddr, 32'd0);
        check("t6_rst_instr", InstrD, NOP);
        check("t6_rst_pcd",   PCD, 32'd0);
        check("t6_rst_pc4",   PCPlus4D, 32'd0);
        check("t6_rst_valid", {31'd0, ValidD}, 32'd0);
`ifdef FETCH_PERF_EN
        check("t6_rst_fetchcnt", FetchCount, 32'd0);
        check("t6_rst_stallcnt", StallCount, 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        check("t6_first_req",  {31'd0, ImemReq}, 32'd1);
        check("t6_first_addr", ImemAddr, 32'd0);
        tick();
        check("t6_stale_v",     {31'd0, ValidD}, 32'd0);
        check("t6_stale_instr", InstrD, NOP);
        tick();
        check("t6_wait_v",      {31'd0, ValidD}, 32'd0);
        tick();
        check("t6_instr0", InstrD, mem_word(32'h0));
        check("t6_pcd0",   PCD, 32'h0);
        check("t6_pc4_0",  PCPlus4D, 32'h4);
        check("t6_valid0", {31'd0, ValidD}, 32'd1);
`ifdef FETCH_PERF_EN
        check("t6_fetchcnt", FetchCount, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
